// File: rtl/pu_fifo_pkg.sv
// Shared constants for the pu_fifo stream-out slice.
//   ATTR_INVALID    : attribute bit index flagging a word the upstream FIFO returned without data
//   DEF_DATA_WIDTH  : default data word width
//   DEF_ATTR_WIDTH  : default attribute width
//   DEF_FIFO_SIZE   : default depth of the upstream pu_fifo
package pu_fifo_pkg;

  localparam int unsigned ATTR_INVALID   = 0;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ATTR_WIDTH = 4;
  localparam int unsigned DEF_FIFO_SIZE  = 3;

endpackage

// File: rtl/pu_skid2.sv
// Two-entry in-order buffer holding data + attribute words.
// Ports:
//   clk, rst              : clock, asynchronous active-low reset
//   push, push_data/attr  : write a word (ignored when full unless popping in the same cycle)
//   pop                   : remove the head word (ignored when empty)
//   head_data, head_attr  : oldest stored word (zero after reset)
//   empty, full           : occupancy flags
module pu_skid2
  import pu_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ATTR_WIDTH = DEF_ATTR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic [ATTR_WIDTH-1:0] push_attr,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [ATTR_WIDTH-1:0] head_attr,
  output logic                  empty,
  output logic                  full
);

  logic [DATA_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
  logic [ATTR_WIDTH-1:0] attr0_q, attr0_d, attr1_q, attr1_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  do_push, do_pop;

  assign empty = (cnt_q == 2'd0);
  assign full  = (cnt_q == 2'd2);

  always_comb begin
    data0_d = data0_q;
    data1_d = data1_q;
    attr0_d = attr0_q;
    attr1_d = attr1_q;
    cnt_d   = cnt_q;
    do_pop  = pop && !empty;
    // A full buffer still accepts a word when the head leaves in the same cycle.
    do_push = push && (!full || do_pop);
    case ({do_push, do_pop})
      2'b10: begin
        if (empty) begin
          data0_d = push_data;
          attr0_d = push_attr;
        end else begin
          data1_d = push_data;
          attr1_d = push_attr;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        data0_d = data1_q;
        attr0_d = attr1_q;
        cnt_d   = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          data0_d = push_data;
          attr0_d = push_attr;
        end else begin
          data0_d = data1_q;
          attr0_d = attr1_q;
          data1_d = push_data;
          attr1_d = push_attr;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data0_q <= '0;
      data1_q <= '0;
      attr0_q <= '0;
      attr1_q <= '0;
      cnt_q   <= 2'd0;
    end else begin
      data0_q <= data0_d;
      data1_q <= data1_d;
      attr0_q <= attr0_d;
      attr1_q <= attr1_d;
      cnt_q   <= cnt_d;
    end
  end

  assign head_data = data0_q;
  assign head_attr = attr0_q;

endmodule

// File: rtl/pu_fifo_stream_out.sv
// Drains an upstream pu_fifo into a valid/ready stream.
// Tracks the upstream occupancy from a tap of its write strobe, issues one read at a time,
// captures the returned word one cycle later into a 2-entry skid buffer and presents it.
// Ports:
//   clk, rst              : clock, asynchronous active-low reset
//   fifo_wr_tap           : copy of the upstream write strobe
//   fifo_oe               : read strobe to the upstream FIFO
//   fifo_data, fifo_attr  : upstream read data, valid one cycle after fifo_oe
//   m_valid, m_ready      : stream handshake
//   m_data, m_attr        : stream word
//   overflow, underrun    : sticky error flags
// Build option PU_FIFO_STREAM_OUT_STATS_EN adds xfer_cnt (wrapping) and drop_cnt (saturating).
module pu_fifo_stream_out
  import pu_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ATTR_WIDTH = DEF_ATTR_WIDTH,
  parameter int unsigned FIFO_SIZE  = DEF_FIFO_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_wr_tap,
  output logic                  fifo_oe,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic [ATTR_WIDTH-1:0] fifo_attr,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ATTR_WIDTH-1:0] m_attr,
  output logic                  overflow,
  output logic                  underrun
`ifdef PU_FIFO_STREAM_OUT_STATS_EN
  ,
  output logic [15:0]           xfer_cnt,
  output logic [7:0]            drop_cnt
`endif
);

  localparam int unsigned     OccW   = $clog2(FIFO_SIZE + 1);
  localparam logic [OccW-1:0] OccMax = OccW'(FIFO_SIZE);

  logic [OccW-1:0] occ_q, occ_d;
  logic            rd_pend_q;
  logic            overflow_q, overflow_d;
  logic            underrun_q;
  logic            buf_empty, buf_full;
  logic            cap_push, cap_drop, xfer;

  // Only one read is ever in flight, so "buffered + in-flight < 2" reduces to the buffer having
  // room and no read pending. Depends on state only, never on m_ready.
  assign fifo_oe = (occ_q != '0) && !rd_pend_q && !buf_full;

  assign cap_drop = rd_pend_q && fifo_attr[ATTR_INVALID];
  assign cap_push = rd_pend_q && !fifo_attr[ATTR_INVALID];
  assign xfer     = m_valid && m_ready;

  always_comb begin
    occ_d      = occ_q;
    overflow_d = overflow_q;
    if (fifo_wr_tap && !fifo_oe) begin
      if (occ_q == OccMax) begin
        overflow_d = 1'b1;
      end else begin
        occ_d = occ_q + 1'b1;
      end
    end else if (!fifo_wr_tap && fifo_oe) begin
      occ_d = occ_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q      <= '0;
      rd_pend_q  <= 1'b0;
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      rd_pend_q  <= fifo_oe;
      overflow_q <= overflow_d;
      underrun_q <= underrun_q | cap_drop;
    end
  end

  pu_skid2 #(
    .DATA_WIDTH(DATA_WIDTH),
    .ATTR_WIDTH(ATTR_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .push     (cap_push),
    .push_data(fifo_data),
    .push_attr(fifo_attr),
    .pop      (xfer),
    .head_data(m_data),
    .head_attr(m_attr),
    .empty    (buf_empty),
    .full     (buf_full)
  );

  assign m_valid  = !buf_empty;
  assign overflow = overflow_q;
  assign underrun = underrun_q;

`ifdef PU_FIFO_STREAM_OUT_STATS_EN
  logic [15:0] xfer_cnt_q;
  logic [7:0]  drop_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xfer_cnt_q <= 16'd0;
      drop_cnt_q <= 8'd0;
    end else begin
      if (xfer) begin
        xfer_cnt_q <= xfer_cnt_q + 16'd1;
      end
      if (cap_drop && (drop_cnt_q != 8'hff)) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  assign xfer_cnt = xfer_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: doc/pu_fifo_stream_out.md
PU_FIFO_STREAM_OUT -- requirements
Module: pu_fifo_stream_out

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data word width.
REQ-002 Parameter ATTR_WIDTH, default 4, SHALL set the attribute width.
REQ-003 Parameter FIFO_SIZE, default 3, SHALL be the depth of the upstream pu_fifo.
REQ-004 The port list SHALL be:
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- fifo_wr_tap  in  1  copy of the upstream pu_fifo signal_wr.
- fifo_oe  out  1  read strobe to the pu_fifo signal_oe.
- fifo_data  in  DATA_WIDTH  pu_fifo data_out.
- fifo_attr  in  ATTR_WIDTH  pu_fifo attr_out.
- m_valid  out  1  stream word valid.
- m_ready  in  1  sink accepts.
- m_data  out  DATA_WIDTH  stream data.
- m_attr  out  ATTR_WIDTH  stream attribute.
- overflow  out  1  sticky: write seen while FIFO full.
- underrun  out  1  sticky: word returned with invalid attribute.

Function
REQ-005 The occupancy counter (0..FIFO_SIZE) SHALL increment on fifo_wr_tap, decrement on fifo_oe, and stay unchanged when both occur in one cycle.
REQ-006 fifo_wr_tap without fifo_oe at occupancy FIFO_SIZE SHALL set overflow and leave the counter saturated.
REQ-007 fifo_oe SHALL be a single-cycle pulse, asserted only when occupancy > 0 and (buffered words + in-flight reads) < 2.
REQ-008 fifo_data/fifo_attr SHALL be sampled exactly one cycle after fifo_oe and written into the 2-entry skid buffer.
REQ-009 Latency: fifo_oe in cycle N -> m_valid high in cycle N+2 when the buffer was empty.
REQ-010 A sampled word whose attr bit ATTR_INVALID is 1 SHALL be dropped and SHALL set underrun.
REQ-011 A transfer SHALL occur when m_valid and m_ready are both high; the buffer SHALL pop in that cycle.
REQ-012 While m_valid is high and m_ready is low, m_data and m_attr SHALL hold stable.
REQ-013 Words SHALL leave in FIFO order with no loss or duplication.
REQ-014 Capture and pop in the same cycle with the buffer full SHALL succeed without stall.
REQ-015 m_ready SHALL have no combinational path to fifo_oe.

Reset
REQ-016 While rst=0: fifo_oe=0, m_valid=0, m_data=0, m_attr=0, overflow=0, underrun=0, occupancy=0, buffer empty, in-flight cleared.
REQ-017 A read in flight when reset asserts SHALL be discarded.

Configuration
REQ-018 With PU_FIFO_STREAM_OUT_STATS_EN defined, the block SHALL add outputs xfer_cnt[15:0] (wrapping count of transfers) and drop_cnt[7:0] (saturating count of dropped words), both reset to 0.
REQ-019 Without PU_FIFO_STREAM_OUT_STATS_EN, these ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-020 Shared package pu_fifo_pkg SHALL hold the ATTR_INVALID bit index (0) and the default DATA_WIDTH, ATTR_WIDTH and FIFO_SIZE constants.
REQ-021 The 2-entry buffer SHALL be a sub-module named pu_skid2 (data+attr, push/pop, full/empty).

Verification
REQ-022 Write 11/attr 2 with m_ready=1 -> fifo_oe one cycle later, m_valid with m_data=11, m_attr=2 two cycles after fifo_oe.
REQ-023 Write 12, 13, 14 back-to-back with m_ready=0 -> two fifo_oe pulses only, m_data holds 12; release m_ready -> 12, 13, 14 in order.
REQ-024 Fourth write while occupancy=3 and no read possible -> overflow=1, remains 1 until reset.
REQ-025 Force fifo_attr=1 on a returned word -> word not presented, underrun=1, next word 15 delivered normally.
REQ-026 Simultaneous fifo_wr_tap and fifo_oe at occupancy 1 -> occupancy stays 1.
REQ-027 Assert rst=0 in the cycle after fifo_oe -> all outputs 0, no word appears after release.
